seg_scan_reader: RTL

Receive-side monitor for the multiplexed seven-segment bus: samples the active-low segment, decimal-point and anode lines, waits for the pattern to settle, and converts each lit glyph back to its 4-bit code. The eight captured digits, their decimal points and per-digit status are held in registers. Used in display loopback self-test and as a bench/debug probe on the board's display pins.

---
 rtl/seg_scan_reader.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_reader.sv
// -----------------------------------------------------------------------------
// seg_scan_reader
//
// Receive-side monitor for a multiplexed, active-low seven-segment bus.
// The segment, decimal-point and anode lines are registered. Each time the
// registered vector has been stable for SETTLE_CYCLES samples, the lit glyph
// is converted back to its 4-bit code and stored against the selected digit.
// A settled vector is captured only once, however long it is held.
//
// Parameters
//   SETTLE_CYCLES  consecutive identical samples before capture (1..255)
//   DIGIT_MASK     digit positions that must be captured to complete a frame
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_n[6:0]   segments a..g on bits 0..6, active-low
//   dp_n         decimal point, active-low
//   an_n[7:0]    digit anodes, active-low, bit i selects digit i
//   digits[31:0] captured codes, digit i on bits 4i+3:4i
//   dp_out[7:0]  captured decimal point per digit, 1 = lit
//   digit_valid  digit i captured at least once since reset
//   bad_glyph    last capture of digit i was not a legal glyph
//   frame_done   one-cycle pulse once every DIGIT_MASK digit has been seen
//   frame_err    one-cycle pulse on a settled vector with >1 anode low
//
// Build option
//   SEG_SCAN_READER_SYNC_EN : when defined, the input stage is a two-flop
//   synchronizer per bit (one extra cycle of latency). Leave undefined only
//   when the display bus is generated in the clk domain.
// -----------------------------------------------------------------------------
module seg_scan_reader #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [7:0]  DIGIT_MASK    = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_n,
   input  logic        dp_n,
   input  logic [7:0]  an_n,
   output logic [31:0] digits,
   output logic [7:0]  dp_out,
   output logic [7:0]  digit_valid,
   output logic [7:0]  bad_glyph,
   output logic        frame_done,
   output logic        frame_err
);

   localparam logic [7:0]  SETTLE_VAL = 8'(SETTLE_CYCLES);
   localparam logic [15:0] IDLE_VEC   = 16'hFFFF;  // blank, nothing selected

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   // Sampled vector layout: {an_n[7:0], dp_n, seg_n[6:0]}
   logic [15:0] pins;
   logic [15:0] samp;
   logic [15:0] last;

   logic        change;
   logic [7:0]  cnt;
   logic [7:0]  run;
   logic        capture;

   logic [6:0]  lit;
   logic [3:0]  code;
   logic        legal;

   logic [7:0]  sel;
   logic        one_hot;
   logic        multi;

   logic [7:0]  seen;
   logic [7:0]  seen_next;
   logic        frame_hit;

   logic [31:0] digits_next;
   logic [7:0]  dp_next;
   logic [7:0]  valid_next;
   logic [7:0]  bad_next;

   assign pins = {an_n, dp_n, seg_n};

   // --------------------------------------------------------------------------
   // Input stage
   // --------------------------------------------------------------------------
`ifdef SEG_SCAN_READER_SYNC_EN
   logic [15:0] sync1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= IDLE_VEC;
         samp  <= IDLE_VEC;
      end else begin
         sync1 <= pins;
         samp  <= sync1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         samp <= IDLE_VEC;
      end else begin
         samp <= pins;
      end
   end
`endif

   // Previous sample, used only for change detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         last <= IDLE_VEC;
      end else begin
         last <= samp;
      end
   end

   assign change = (samp != last);

   // --------------------------------------------------------------------------
   // Stability counter
   // run is the number of consecutive samples equal to the current one,
   // counting the current sample itself; a fresh value therefore starts at 1.
   // It saturates so a vector held forever cannot wrap back onto SETTLE_VAL.
   // --------------------------------------------------------------------------
   always_comb begin
      run = 8'd1;
      if (!change) begin
         run = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
      end else begin
         cnt <= run;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: SETTLE waits for a stable run, HOLD blocks repeat captures until the
   // vector changes. A change while in HOLD also qualifies, which only matters
   // when SETTLE_CYCLES is 1 and the very first sample must be captured.
   // --------------------------------------------------------------------------
   assign capture = (run == SETTLE_VAL) && ((state == SETTLE) || change);

   always_comb begin
      state_next = state;
      if (capture) begin
         state_next = HOLD;
      end else if (change) begin
         state_next = SETTLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SETTLE;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // Glyph decode (lit bits: g f e d c b a)
   // --------------------------------------------------------------------------
   assign lit = ~samp[6:0];

   always_comb begin
      code  = 4'h0;
      legal = 1'b1;
      case (lit)
         7'h3F:   code = 4'h0;
         7'h06:   code = 4'h1;
         7'h5B:   code = 4'h2;
         7'h4F:   code = 4'h3;
         7'h66:   code = 4'h4;
         7'h6D:   code = 4'h5;
         7'h7C:   code = 4'h6;
         7'h07:   code = 4'h7;
         7'h7F:   code = 4'h8;
         7'h67:   code = 4'h9;
         7'h58:   code = 4'hA;
         7'h4C:   code = 4'hB;
         7'h62:   code = 4'hC;
         7'h69:   code = 4'hD;
         7'h78:   code = 4'hE;
         7'h00:   code = 4'hF;
         default: begin
            code  = 4'h0;
            legal = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Anode classification
   // --------------------------------------------------------------------------
   assign sel     = ~samp[15:8];
   assign one_hot = (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
   assign multi   = (sel != 8'h00) && !one_hot;

   // --------------------------------------------------------------------------
   // Capture datapath
   // --------------------------------------------------------------------------
   always_comb begin
      digits_next = digits;
      dp_next     = dp_out;
      valid_next  = digit_valid;
      bad_next    = bad_glyph;
      if (capture && one_hot) begin
         for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
               digits_next[4*i +: 4] = legal ? code : 4'h0;
               dp_next[i]            = ~samp[7];
               valid_next[i]         = 1'b1;
               bad_next[i]           = ~legal;
            end
         end
      end
   end

   // Frame completion is judged on the registered seen set: the pulse comes
   // one edge after the completing capture, and seen restarts empty apart
   // from any capture landing on that same edge.
   assign frame_hit = ((seen & DIGIT_MASK) == DIGIT_MASK);

   always_comb begin
      seen_next = frame_hit ? 8'h00 : seen;
      if (capture && one_hot) begin
         seen_next = seen_next | sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits      <= 32'h0;
         dp_out      <= 8'h00;
         digit_valid <= 8'h00;
         bad_glyph   <= 8'h00;
         seen        <= 8'h00;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         digits      <= digits_next;
         dp_out      <= dp_next;
         digit_valid <= valid_next;
         bad_glyph   <= bad_next;
         seen        <= seen_next;
         frame_done  <= frame_hit;
         frame_err   <= capture && multi;
      end
   end

endmodule
